// File: rtl/pll_reset_sequencer_if.sv
// rtl/pll_reset_sequencer_if.sv - PLL lock input and reset/status outputs of the reset sequencer
interface pll_reset_sequencer_if;
  logic       locked;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       lock_lost;
  logic [7:0] retry_count;

  // The sequencer drives resets and status and observes the PLL lock.
  modport master (
    input  locked,
    output pll_rst,
    output sys_rst,
    output ready,
    output lock_lost,
    output retry_count
  );

  // The PLL / system side supplies lock and consumes the resets and status.
  modport slave (
    output locked,
    input  pll_rst,
    input  sys_rst,
    input  ready,
    input  lock_lost,
    input  retry_count
  );
endinterface

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL reset pulse, lock supervision and system reset release on refclk
module pll_reset_sequencer #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
  input  logic                  refclk,
  input  logic                  rst,
  pll_reset_sequencer_if.master pif
);

  // One counter serves every timed state, so it must hold the largest terminal count.
  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [CW-1:0] PRST_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STB_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(LOCK_TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_PLL_RESET = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABILIZE = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  state_t        state;
  state_t        next_state;
  logic [CW-1:0] cnt;
  logic          bump_retry;
  logic          set_lost;

  logic          lock_meta;
  logic          locked_s;

  logic          pll_rst_q;
  logic          sys_rst_q;
  logic          ready_q;
  logic          lock_lost_q;
  logic [7:0]    retry_q;

  // Two-flop synchronizer for the asynchronous PLL lock indicator.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= pif.locked;
      locked_s  <= lock_meta;
    end
  end

  // State register.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state <= S_PLL_RESET;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode; lock is tested before the timeout so a coincident lock wins.
  always_comb begin
    next_state = state;
    bump_retry = 1'b0;
    set_lost   = 1'b0;
    case (state)
      S_PLL_RESET: begin
        if (cnt == PRST_LAST) begin
          next_state = S_WAIT_LOCK;
        end
      end
      S_WAIT_LOCK: begin
        if (locked_s) begin
          next_state = S_STABILIZE;
        end else if (cnt == TMO_LAST) begin
          next_state = S_PLL_RESET;
          bump_retry = 1'b1;
        end
      end
      S_STABILIZE: begin
        if (!locked_s) begin
          next_state = S_WAIT_LOCK;
        end else if (cnt == STB_LAST) begin
          next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (!locked_s) begin
          next_state = S_PLL_RESET;
          bump_retry = 1'b1;
          set_lost   = 1'b1;
        end
      end
      default: begin
        next_state = S_PLL_RESET;
      end
    endcase
  end

  // Shared cycle counter: restarts on every state change, idles in RUN where nothing is timed.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (next_state != state) begin
      cnt <= '0;
    end else if (state != S_RUN) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Outputs are registered from the next state so they switch on the same edge as the state.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      pll_rst_q   <= 1'b1;
      sys_rst_q   <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      retry_q     <= 8'd0;
    end else begin
      pll_rst_q <= (next_state == S_PLL_RESET);
      sys_rst_q <= (next_state != S_RUN);
      ready_q   <= (next_state == S_RUN);
      if (set_lost) begin
        lock_lost_q <= 1'b1;
      end
      if (bump_retry && (retry_q != 8'hFF)) begin
        retry_q <= retry_q + 8'd1;
      end
    end
  end

  assign pif.pll_rst     = pll_rst_q;
  assign pif.sys_rst     = sys_rst_q;
  assign pif.ready       = ready_q;
  assign pif.lock_lost   = lock_lost_q;
  assign pif.retry_count = retry_q;

endmodule

// File: doc/pll_reset_sequencer.md
# pll_reset_sequencer

Reset and lock supervisor that sits directly downstream of the system PLL and runs on the free-running 50 MHz reference clock. It pulses the PLL reset at power-up and synchronizes the PLL `locked` output. It holds the system reset until lock has been stable for a programmable time, and re-runs the PLL reset sequence on lock timeout or lock loss. `sys_rst` feeds the per-domain reset synchronizers of the 150 MHz and UART-baud clock domains.

## Interface
- `PLL_RST_CYCLES`, default 16: refclk cycles that `pll_rst` is held high per reset attempt; must be ≥1.
- `LOCK_STABLE_CYCLES`, default 1024: consecutive synchronized-lock cycles required before system reset is released; must be ≥1.
- `LOCK_TIMEOUT_CYCLES`, default 65536: refclk cycles to wait for lock before retrying; must be ≥1.
- `refclk` in 1: free-running 50 MHz reference clock; the only clock.
- `rst` in 1: asynchronous, active-high reset.
- `locked` in 1: PLL lock indicator, asynchronous to `refclk`.
- `pll_rst` out 1: reset to the PLL `rst` input.
- `sys_rst` out 1: active-high system reset request, registered.
- `ready` out 1: high only in RUN.
- `lock_lost` out 1: sticky flag, set when lock drops while in RUN; cleared only by `rst`.
- `retry_count` out 8: count of re-entries to PLL_RESET; saturates at 255.

## Operation
- `locked` passes through a 2-FF synchronizer (reset value 0) to form `locked_s`. Only `locked_s` is used.
- One shared cycle counter, width `$clog2` of the largest parameter plus 1. It is cleared on every state change.
- States and transitions:
  - **PLL_RESET**
    - Outputs: `pll_rst`=1, `sys_rst`=1, `ready`=0.
    - On the edge where counter == `PLL_RST_CYCLES`-1, go to WAIT_LOCK.
  - **WAIT_LOCK**
    - Outputs: `pll_rst`=0, `sys_rst`=1.
    - If `locked_s`=1, go to STABILIZE.
    - Else, if counter == `LOCK_TIMEOUT_CYCLES`-1, go to PLL_RESET and increment `retry_count`.
  - **STABILIZE**
    - Outputs: `pll_rst`=0, `sys_rst`=1.
    - If `locked_s`=0, go to WAIT_LOCK. This is a glitch, not a retry: `retry_count` is unchanged.
    - Else, if counter == `LOCK_STABLE_CYCLES`-1, go to RUN.
  - **RUN**
    - Outputs: `pll_rst`=0, `sys_rst`=0, `ready`=1.
    - If `locked_s`=0, go to PLL_RESET, set `lock_lost`, and increment `retry_count`.
- All outputs are registered and change on the same edge as the state register. There is no combinational path from any input to any output.
- `retry_count` saturates at 255 and does not wrap.
- If the WAIT_LOCK timeout and `locked_s`=1 occur on the same edge, lock wins: go to STABILIZE with no retry increment.
- Reset values: state PLL_RESET, counter 0, `pll_rst`=1, `sys_rst`=1, `ready`=0, `lock_lost`=0, `retry_count`=0, synchronizer 0.
- Asserting `rst` at any time, including mid-STABILIZE or in RUN, forces all reset values immediately (asynchronous). No retry is counted.

## Timing
- Edge 1 is the first `refclk` rising edge after `rst` deasserts. `pll_rst` stays high through edges 1..`PLL_RST_CYCLES` and is low after edge `PLL_RST_CYCLES`.
- Lock synchronizer latency: if `locked` rises before edge k (setup met), `locked_s` is 1 after edge k+1 and the state is STABILIZE after edge k+2.
- From STABILIZE entry, `ready`=1 and `sys_rst`=0 after exactly `LOCK_STABLE_CYCLES` further edges, provided `locked_s` stays high.
- WAIT_LOCK lasts exactly `LOCK_TIMEOUT_CYCLES` cycles when no lock arrives.
- Lock loss in RUN: if `locked` falls before edge k, then after edge k+2:
  - `sys_rst`=1, `pll_rst`=1, `ready`=0, `lock_lost`=1;
  - `retry_count` has incremented by 1.
- Any `locked` pulse, high or low, shorter than one `refclk` period may be missed. The PLL guarantees longer pulses.

## Test plan
Bench parameters: `PLL_RST_CYCLES`=4, `LOCK_STABLE_CYCLES`=8, `LOCK_TIMEOUT_CYCLES`=32.
- **Power-up:** release `rst`, `locked` high from edge 10 → `pll_rst` high for edges 1–4; STABILIZE after edge 12; `ready`=1 and `sys_rst`=0 after edge 20; `retry_count`=0.
- **Timeout:** `locked` held low → `pll_rst` re-asserts after edge 36, then again after edge 72; `retry_count` reads 1, then 2; `ready` never rises.
- **Stabilize glitch:** `locked` drops for 3 cycles mid-STABILIZE → return to WAIT_LOCK; after re-lock the full 8-cycle stabilize window restarts; `retry_count` unchanged.
- **Loss in RUN:** `locked` falls before edge k in RUN → after edge k+2: `sys_rst`=1, `pll_rst`=1, `lock_lost`=1, `retry_count`+1. After re-lock, `ready` returns; `lock_lost` stays 1.
- **Saturation and async reset:** force 300 timeouts → `retry_count`=255. Assert `rst` mid-RUN (between edges) → all outputs take reset values immediately, before the next edge, and `lock_lost`=0.
